tick_debouncer: RTL

//  - Debounces one raw mechanical input using the periodic enable tick from the free-running binary counter (its max_tick output).
//  - Sits directly downstream of that counter. The counter sets the sample period; this block decides stability with a 4-state FSM.
//  - Outputs a clean level plus single-cycle rise and fall pulses for the control logic that follows.

---
 rtl/tick_debouncer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tick_debouncer.sv
// tick_debouncer: debounces one raw input using a periodic sample tick.
// A 4-state FSM (ZERO, WAIT1, ONE, WAIT0) requires the input to hold a new
// value for STABLE_TICKS consecutive ticks before the clean level follows.
// Optional feature macro: DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser
// (2 clk of extra latency); without it sw must already be synchronous to clk.
module tick_debouncer #(
  parameter int STABLE_TICKS = 3,
  parameter int CW           = 4
) (
  input  logic clk,
  input  logic reset,     // synchronous, active-low
  input  logic tick,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall,
  output logic busy
);

  // Reject an unusable tick count at elaboration time.
  if (STABLE_TICKS < 1 || STABLE_TICKS > (2 ** CW) - 1) begin : g_bad_stable_ticks
    $error("tick_debouncer: STABLE_TICKS must be in 1..(2**CW)-1");
  end

  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_ONE   = 2'd2;
  localparam logic [1:0] ST_WAIT0 = 2'd3;

  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s_in;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_level_q, db_level_d;
  logic          db_rise_q, db_rise_d;
  logic          db_fall_q, db_fall_d;
  logic          busy_q, busy_d;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign s_in = sync2_q;
`else
  assign s_in = sw;
`endif

  // Next-state logic: a reversal always beats a tick, and the entry cycle
  // into a WAIT state only loads the counter (a coincident tick is ignored).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ZERO: begin
        if (s_in) begin
          state_d = ST_WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT1: begin
        if (!s_in) begin
          state_d = ST_ZERO;
        end else if (tick && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_ONE;
          end
        end
      end
      ST_ONE: begin
        if (!s_in) begin
          state_d = ST_WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT0: begin
        if (s_in) begin
          state_d = ST_ONE;
        end else if (tick && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_ZERO;
          end
        end
      end
      default: begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is registered yet
  // changes on the same edge as the state; pulses only on completed waits.
  always_comb begin
    db_level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
    busy_d     = (state_d == ST_WAIT1) || (state_d == ST_WAIT0);
    db_rise_d  = (state_q == ST_WAIT1) && (state_d == ST_ONE);
    db_fall_d  = (state_q == ST_WAIT0) && (state_d == ST_ZERO);
  end

  // State, counter and output registers; reset wins from any state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_ZERO;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      db_rise_q  <= 1'b0;
      db_fall_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      db_rise_q  <= db_rise_d;
      db_fall_q  <= db_fall_d;
      busy_q     <= busy_d;
    end
  end

  assign db_level = db_level_q;
  assign db_rise  = db_rise_q;
  assign db_fall  = db_fall_q;
  assign busy     = busy_q;

endmodule
